whack_game_ctrl: RTL and testbench
==================================

Name: whack_game_ctrl

Overview:
- Parametrised game controller for the reaction game: lights one of NUM_MOLES targets, times the player's response, and keeps score, lives and round count.
- Adds features beyond the fixed 4-button controller: N channels, a shrinking reaction window, lives, round limit, button synchronisation, release gating, and no immediate repeat of a target.
- Sits between the board buttons/LEDs and the score display decoders.

Parameters:
NUM_MOLES, 4, number of buttons/lights (2..16)
SCORE_W, 8, score counter width
ROUNDS, 16, rounds per game (1..2^SCORE_W-1)
LIVES, 3, misses allowed before game over (1..15)
TIMEOUT_INIT, 50000000, initial reaction window in clk cycles
TIMEOUT_MIN, 10000000, floor of reaction window
TIMEOUT_STEP, 2500000, window reduction per hit
GAP_CYCLES, 12500000, lights-off pause between rounds
LFSR_SEED, 16'hACE1, nonzero 16-bit LFSR seed

Ports:
clk  input  1  system clock
rst  input  1  asynchronous active-low reset (0 = reset)
start  input  1  level input; a rising edge starts a game from IDLE or DONE
buttons  input  NUM_MOLES  raw asynchronous player buttons, active-high
lights  output  NUM_MOLES  one-hot target light; all zero when no target is shown
score  output  SCORE_W  hits in the current game
lives_left  output  4  remaining lives
round_cnt  output  SCORE_W  completed rounds
hit_pulse  output  1  one-cycle pulse on a hit
miss_pulse  output  1  one-cycle pulse on a miss
busy  output  1  high from ARM through GAP
done  output  1  high in DONE

Behaviour:
- Reset (rst=0, asynchronous):
  - State IDLE; lights=0, score=0, round_cnt=0, lives_left=LIVES, pulses=0, busy=0, done=0.
  - LFSR=LFSR_SEED; cur_timeout=TIMEOUT_INIT; prev_idx=NUM_MOLES-1.
  - A reset mid-game aborts the game immediately and returns to this same state.
- Input conditioning:
  - buttons and start each pass through a 2-FF synchronizer.
  - press[i] = synced & ~synced_d (rising edge).
  - Total latency from pin to the FSM acting on a press is 3 clk.
- LFSR: 16-bit Galois, taps x^16+x^14+x^13+x^11+1, advances every cycle; the value 0 is never produced.
- States:
  - IDLE: outputs held. On a start edge: clear score, round_cnt and pulses, load lives_left=LIVES and cur_timeout=TIMEOUT_INIT, then go to ARM.
  - ARM (1 cycle):
    - cand = LFSR % NUM_MOLES.
    - If cand==prev_idx, idx=(cand+1)%NUM_MOLES; otherwise idx=cand.
    - Load timer=cur_timeout-1, then go to SHOW.
  - SHOW: lights=1<<idx. Transitions are evaluated in priority order:
    1. Any press on a non-target button → MISS. This includes a wrong press in the same cycle as a correct press.
    2. Press on the target button only → HIT.
    3. timer==0 → MISS. The target is lit for exactly cur_timeout cycles.
    4. Otherwise the timer decrements.
  - HIT (1 cycle):
    - hit_pulse=1; score+1, saturating at all-ones.
    - cur_timeout = max(cur_timeout-TIMEOUT_STEP, TIMEOUT_MIN), with no underflow.
    - round_cnt+1, prev_idx=idx, lights=0; go to GAP.
  - MISS (1 cycle):
    - miss_pulse=1; lives_left-1; round_cnt+1, prev_idx=idx, lights=0.
    - If lives_left==1 before the decrement, go to DONE; otherwise go to GAP.
  - GAP:
    - lights=0; count GAP_CYCLES cycles.
    - Leave only once the count has expired AND all synced buttons are low; held buttons extend the gap.
    - If round_cnt==ROUNDS, go to DONE; otherwise go to ARM.
  - DONE:
    - done=1, busy=0.
    - score, round_cnt and lives_left are frozen for display.
    - A start edge restarts the game as described for IDLE.
- Presses outside SHOW are ignored.
- A start edge while busy is ignored.
- hit_pulse and miss_pulse are never high in the same cycle.
- lights is registered and always one-hot or zero.

Test Plan:
- Params NUM_MOLES=4, TIMEOUT_INIT=20, TIMEOUT_MIN=10, TIMEOUT_STEP=5, GAP_CYCLES=4, LIVES=2, ROUNDS=4. Hold rst=0, release, pulse start → lights one-hot within 5 clk, busy=1, score=0, lives_left=2.
- Press the lit button 3 clk after the light appears → hit_pulse one cycle, score=1, round_cnt=1, lights=0. The next window measures 15 cycles, then 10, then stays at 10 after further hits.
- No press → lights held exactly 20 cycles, then miss_pulse, lives_left=1. A second timeout → done=1, lives_left=0, round_cnt=2.
- Press the lit button and a wrong button in the same clk → miss_pulse, no score change.
- Four consecutive hits → done=1 after the 4th GAP, score=4. Check that no two consecutive rounds light the same index. Hold a button through GAP → ARM is delayed until release.
- Assert rst=0 mid-SHOW → lights=0, score=0, IDLE immediately (asynchronous). A start edge while busy → no effect.

Source files
------------

// File: rtl/whack_game_ctrl.sv
// Reaction-game controller: lights one of NUM_MOLES targets, times the response,
// and tracks score, lives and rounds with a shrinking reaction window.
module whack_game_ctrl #(
    parameter int unsigned NUM_MOLES    = 4,
    parameter int unsigned SCORE_W      = 8,
    parameter int unsigned ROUNDS       = 16,
    parameter int unsigned LIVES        = 3,
    parameter int unsigned TIMEOUT_INIT = 50000000,
    parameter int unsigned TIMEOUT_MIN  = 10000000,
    parameter int unsigned TIMEOUT_STEP = 2500000,
    parameter int unsigned GAP_CYCLES   = 12500000,
    parameter logic [15:0] LFSR_SEED    = 16'hACE1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [NUM_MOLES-1:0] buttons,
    output logic [NUM_MOLES-1:0] lights,
    output logic [SCORE_W-1:0]   score,
    output logic [3:0]           lives_left,
    output logic [SCORE_W-1:0]   round_cnt,
    output logic                 hit_pulse,
    output logic                 miss_pulse,
    output logic                 busy,
    output logic                 done
);

    localparam int unsigned IW = (NUM_MOLES > 1) ? $clog2(NUM_MOLES) : 1;
    localparam int unsigned TW = $clog2(TIMEOUT_INIT + TIMEOUT_STEP + 1);
    localparam int unsigned GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

    localparam logic [IW-1:0]      LAST_IDX = IW'(NUM_MOLES - 1);
    localparam logic [TW-1:0]      T_INIT   = TW'(TIMEOUT_INIT);
    localparam logic [TW-1:0]      T_MIN    = TW'(TIMEOUT_MIN);
    localparam logic [TW-1:0]      T_STEP   = TW'(TIMEOUT_STEP);
    localparam logic [GW-1:0]      G_LOAD   = GW'(GAP_CYCLES - 1);
    localparam logic [3:0]         L_INIT   = 4'(LIVES);
    localparam logic [SCORE_W-1:0] R_LAST   = SCORE_W'(ROUNDS);
    localparam logic [NUM_MOLES-1:0] ONE    = {{(NUM_MOLES-1){1'b0}}, 1'b1};

    typedef enum logic [2:0] {
        S_IDLE, S_ARM, S_SHOW, S_HIT, S_MISS, S_GAP, S_DONE
    } state_t;

    state_t state, next_state;

    logic [NUM_MOLES-1:0] btn_meta, btn_sync, btn_prev, press;
    logic                 start_meta, start_sync, start_prev, start_edge;
    logic [15:0]          lfsr;
    logic [IW-1:0]        cand, next_idx, idx, prev_idx;
    logic [NUM_MOLES-1:0] target;
    logic                 wrong_press, right_press;
    logic [TW-1:0]        cur_timeout, timer;
    logic [GW-1:0]        gap_cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            btn_meta   <= '0;
            btn_sync   <= '0;
            btn_prev   <= '0;
            start_meta <= 1'b0;
            start_sync <= 1'b0;
            start_prev <= 1'b0;
        end else begin
            btn_meta   <= buttons;
            btn_sync   <= btn_meta;
            btn_prev   <= btn_sync;
            start_meta <= start;
            start_sync <= start_meta;
            start_prev <= start_sync;
        end
    end

    assign press      = btn_sync & ~btn_prev;
    assign start_edge = start_sync & ~start_prev;

    // Galois form, taps x^16+x^14+x^13+x^11+1
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) lfsr <= LFSR_SEED;
        else      lfsr <= {1'b0, lfsr[15:1]} ^ (lfsr[0] ? 16'hB400 : 16'h0000);
    end

    assign cand = IW'(lfsr % 16'(NUM_MOLES));

    always_comb begin
        next_idx = cand;
        if (cand == prev_idx)
            next_idx = (cand == LAST_IDX) ? '0 : cand + 1'b1;
    end

    assign target      = ONE << idx;
    assign wrong_press = |(press & ~target);
    assign right_press = |(press & target);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= S_IDLE;
        else      state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            S_IDLE, S_DONE: if (start_edge) next_state = S_ARM;
            S_ARM:          next_state = S_SHOW;
            S_SHOW: begin
                if (wrong_press)        next_state = S_MISS;
                else if (right_press)   next_state = S_HIT;
                else if (timer == '0)   next_state = S_MISS;
            end
            S_HIT:          next_state = S_GAP;
            S_MISS:         next_state = (lives_left == 4'd1) ? S_DONE : S_GAP;
            S_GAP: begin
                if (gap_cnt == '0 && btn_sync == '0)
                    next_state = (round_cnt == R_LAST) ? S_DONE : S_ARM;
            end
            default:        next_state = S_IDLE;
        endcase
    end

    always_comb begin
        busy       = (state == S_ARM) || (state == S_SHOW) || (state == S_HIT) ||
                     (state == S_MISS) || (state == S_GAP);
        done       = (state == S_DONE);
        hit_pulse  = (state == S_HIT);
        miss_pulse = (state == S_MISS);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            lights      <= '0;
            score       <= '0;
            round_cnt   <= '0;
            lives_left  <= L_INIT;
            cur_timeout <= T_INIT;
            timer       <= '0;
            gap_cnt     <= '0;
            idx         <= '0;
            prev_idx    <= LAST_IDX;
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    if (start_edge) begin
                        score       <= '0;
                        round_cnt   <= '0;
                        lives_left  <= L_INIT;
                        cur_timeout <= T_INIT;
                    end
                end
                S_ARM: begin
                    idx    <= next_idx;
                    timer  <= cur_timeout - 1'b1;
                    lights <= ONE << next_idx;
                end
                S_SHOW: begin
                    // lights drop on the same edge the FSM leaves SHOW
                    if (next_state != S_SHOW) lights <= '0;
                    else                      timer  <= timer - 1'b1;
                end
                S_HIT: begin
                    if (score != '1) score <= score + 1'b1;
                    cur_timeout <= (cur_timeout >= T_MIN + T_STEP) ? cur_timeout - T_STEP : T_MIN;
                    round_cnt   <= round_cnt + 1'b1;
                    prev_idx    <= idx;
                    gap_cnt     <= G_LOAD;
                end
                S_MISS: begin
                    lives_left <= lives_left - 4'd1;
                    round_cnt  <= round_cnt + 1'b1;
                    prev_idx   <= idx;
                    gap_cnt    <= G_LOAD;
                end
                S_GAP: begin
                    if (gap_cnt != '0) gap_cnt <= gap_cnt - 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_whack_game_ctrl.sv
// Directed bench for whack_game_ctrl with a small, fast parameter set.
module tb_whack_game_ctrl;

    localparam int unsigned N = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [N-1:0] buttons;
    logic [N-1:0] lights;
    logic [7:0]   score;
    logic [3:0]   lives_left;
    logic [7:0]   round_cnt;
    logic         hit_pulse, miss_pulse, busy, done;

    int unsigned  n_cmp = 0;
    int unsigned  n_err = 0;
    logic [N-1:0] tgt, prev, other;
    int unsigned  lit_cnt;

    whack_game_ctrl #(
        .NUM_MOLES(4), .SCORE_W(8), .ROUNDS(4), .LIVES(2),
        .TIMEOUT_INIT(20), .TIMEOUT_MIN(10), .TIMEOUT_STEP(5),
        .GAP_CYCLES(4), .LFSR_SEED(16'hACE1)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .buttons(buttons),
        .lights(lights), .score(score), .lives_left(lives_left),
        .round_cnt(round_cnt), .hit_pulse(hit_pulse), .miss_pulse(miss_pulse),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed no finish, required finish before 200000");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int unsigned n);
        for (int unsigned i = 0; i < n; i++) tick();
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic pulse_start();
        start = 1'b1;
        ticks(3);
        start = 1'b0;
    endtask

    task automatic wait_lights(input string tag, input int unsigned bound);
        int unsigned i = 0;
        while (lights == '0 && i < bound) begin
            tick();
            i++;
        end
        chk({tag, "_lit"}, 32'(lights != '0), 1);
        chk({tag, "_onehot"}, 32'($onehot(lights)), 1);
    endtask

    task automatic wait_done(input string tag, input int unsigned bound);
        int unsigned i = 0;
        while (!done && i < bound) begin
            tick();
            i++;
        end
        chk(tag, 32'(done), 1);
    endtask

    // Press the lit button three cycles after it appears; the hit is seen 3 clk later.
    task automatic do_hit(input string tag, input logic [7:0] exp_score,
                          input logic [7:0] exp_round, input bit hold);
        tgt = lights;
        ticks(3);
        buttons = tgt;
        ticks(3);
        chk({tag, "_hit_pulse"}, 32'(hit_pulse), 1);
        chk({tag, "_no_miss"}, 32'(miss_pulse), 0);
        chk({tag, "_lights_off"}, 32'(lights), 0);
        if (!hold) buttons = '0;
        tick();
        chk({tag, "_pulse_end"}, 32'(hit_pulse), 0);
        chk({tag, "_score"}, 32'(score), 32'(exp_score));
        chk({tag, "_round"}, 32'(round_cnt), 32'(exp_round));
    endtask

    // Count lit cycles with no press; the sample after the last lit one is MISS.
    task automatic measure(input string tag, input int unsigned exp_len);
        int unsigned cnt = 0;
        while (lights != '0 && cnt < 200) begin
            cnt++;
            tick();
        end
        chk({tag, "_window"}, cnt, exp_len);
        chk({tag, "_miss_pulse"}, 32'(miss_pulse), 1);
        chk({tag, "_no_hit"}, 32'(hit_pulse), 0);
    endtask

    initial begin
        rst = 1'b0; start = 1'b0; buttons = '0;
        ticks(3);
        chk("rst_lights", 32'(lights), 0);
        chk("rst_score", 32'(score), 0);
        chk("rst_lives", 32'(lives_left), 2);
        chk("rst_round", 32'(round_cnt), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_pulses", 32'({hit_pulse, miss_pulse}), 0);
        rst = 1'b1;
        tick();

        // Game A: three hits shrink the window 20 -> 15 -> 10 -> 10, then a timeout
        pulse_start();
        wait_lights("a1", 5);
        chk("a1_busy", 32'(busy), 1);
        chk("a1_score0", 32'(score), 0);
        chk("a1_lives", 32'(lives_left), 2);
        prev = lights;
        do_hit("a1", 8'd1, 8'd1, 1'b0);
        wait_lights("a2", 20);
        chk("a2_norepeat", 32'(lights != prev), 1);
        prev = lights;
        do_hit("a2", 8'd2, 8'd2, 1'b0);
        wait_lights("a3", 20);
        chk("a3_norepeat", 32'(lights != prev), 1);
        prev = lights;
        do_hit("a3", 8'd3, 8'd3, 1'b0);
        wait_lights("a4", 20);
        chk("a4_norepeat", 32'(lights != prev), 1);
        measure("a4", 10);
        tick();
        chk("a4_lives", 32'(lives_left), 1);
        chk("a4_round", 32'(round_cnt), 4);
        wait_done("a_done", 20);
        chk("a_busy_done", 32'(busy), 0);
        chk("a_score_final", 32'(score), 3);

        // Game B: two timeouts at the full window end the game
        pulse_start();
        wait_lights("b1", 5);
        chk("b1_score_clr", 32'(score), 0);
        chk("b1_round_clr", 32'(round_cnt), 0);
        chk("b1_lives_rld", 32'(lives_left), 2);
        chk("b1_done_clr", 32'(done), 0);
        prev = lights;
        measure("b1", 20);
        tick();
        chk("b1_lives", 32'(lives_left), 1);
        chk("b1_round", 32'(round_cnt), 1);
        wait_lights("b2", 20);
        chk("b2_norepeat", 32'(lights != prev), 1);
        measure("b2", 20);
        tick();
        chk("b2_done", 32'(done), 1);
        chk("b2_lives", 32'(lives_left), 0);
        chk("b2_round", 32'(round_cnt), 2);

        // Game C: window 15 after one hit; right+wrong press together is a miss
        pulse_start();
        wait_lights("c1", 5);
        do_hit("c1", 8'd1, 8'd1, 1'b0);
        wait_lights("c2", 20);
        measure("c2", 15);
        tick();
        chk("c2_lives", 32'(lives_left), 1);
        chk("c2_round", 32'(round_cnt), 2);
        wait_lights("c3", 20);
        tgt = lights;
        other = {tgt[N-2:0], tgt[N-1]};
        buttons = tgt | other;
        ticks(3);
        chk("c3_miss_pulse", 32'(miss_pulse), 1);
        chk("c3_no_hit", 32'(hit_pulse), 0);
        buttons = '0;
        tick();
        chk("c3_score", 32'(score), 1);
        chk("c3_lives", 32'(lives_left), 0);
        chk("c3_round", 32'(round_cnt), 3);
        chk("c3_done", 32'(done), 1);

        // Game D: four hits, start edge while busy, button held through GAP
        pulse_start();
        wait_lights("d1", 5);
        prev = lights;
        pulse_start();
        chk("d1_busy_start_busy", 32'(busy), 1);
        chk("d1_busy_start_round", 32'(round_cnt), 0);
        chk("d1_busy_start_onehot", 32'($onehot(lights)), 1);
        do_hit("d1", 8'd1, 8'd1, 1'b0);
        wait_lights("d2", 20);
        chk("d2_norepeat", 32'(lights != prev), 1);
        prev = lights;
        do_hit("d2", 8'd2, 8'd2, 1'b1);
        lit_cnt = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (lights != '0) lit_cnt++;
        end
        chk("d2_hold_gap", lit_cnt, 0);
        buttons = '0;
        wait_lights("d3", 10);
        chk("d3_norepeat", 32'(lights != prev), 1);
        prev = lights;
        do_hit("d3", 8'd3, 8'd3, 1'b0);
        wait_lights("d4", 20);
        chk("d4_norepeat", 32'(lights != prev), 1);
        do_hit("d4", 8'd4, 8'd4, 1'b0);
        wait_done("d_done", 20);
        chk("d_score", 32'(score), 4);
        chk("d_round", 32'(round_cnt), 4);
        chk("d_lives", 32'(lives_left), 2);

        // Game E: asynchronous reset in the middle of SHOW
        pulse_start();
        wait_lights("e1", 5);
        do_hit("e1", 8'd1, 8'd1, 1'b0);
        wait_lights("e2", 20);
        tick();
        rst = 1'b0;
        #1;
        chk("e_rst_lights", 32'(lights), 0);
        chk("e_rst_score", 32'(score), 0);
        chk("e_rst_round", 32'(round_cnt), 0);
        chk("e_rst_lives", 32'(lives_left), 2);
        chk("e_rst_busy", 32'(busy), 0);
        ticks(2);
        rst = 1'b1;
        ticks(3);
        chk("e_idle_busy", 32'(busy), 0);
        chk("e_idle_done", 32'(done), 0);
        chk("e_idle_lights", 32'(lights), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
